// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: conversion FSM states, score limit,
// digit-select codes and 7-segment patterns ({g,f,e,d,c,b,a}, active-high).
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam int unsigned MAX_SCORE = 99;

    localparam logic [1:0] SEL_ONES = 2'b01;
    localparam logic [1:0] SEL_TENS = 2'b10;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after doubling.
    function automatic logic [3:0] add3_fix(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/score_display_driver_bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decode; non-decimal codes go blank.
module bcd_to_seg7
    import scoreboard_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Digit pattern lookup
    always_comb begin
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_driver.sv
// Score (0-99) to two-digit multiplexed 7-segment driver with continuous
// double-dabble conversion. Optional macro LEADING_ZERO_BLANK_EN blanks a tens "0".
module score_display_driver
    import scoreboard_pkg::*;
#(
    parameter int BW        = 7,
    parameter int REFRESH_W = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    digit_sel_o,
    output logic [3:0]    bcd_tens_o,
    output logic [3:0]    bcd_ones_o,
    output logic          update_o
);

    localparam int CW = $clog2(BW + 1);

    conv_state_e          state_q;
    logic [BW-1:0]        shift_q;
    logic [7:0]           scratch_q;
    logic [CW-1:0]        bitcnt_q;
    logic [3:0]           tens_q;
    logic [3:0]           ones_q;
    logic                 update_q;
    logic [REFRESH_W-1:0] refresh_q;
    logic [1:0]           sel_q;
    logic [6:0]           seg_q;

    logic [BW-1:0]        clamped_d;
    logic [7:0]           scratch_fix_d;
    logic [3:0]           digit_d;
    logic [6:0]           seg_raw_d;
    logic [6:0]           seg_d;

    assign clamped_d     = (value_i > BW'(MAX_SCORE)) ? BW'(MAX_SCORE) : value_i;
    assign scratch_fix_d = {add3_fix(scratch_q[7:4]), add3_fix(scratch_q[3:0])};

    // Binary-to-BCD conversion FSM with latched digits and update pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= 8'h00;
            bitcnt_q  <= '0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            update_q  <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    shift_q   <= clamped_d;
                    scratch_q <= 8'h00;
                    bitcnt_q  <= '0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {scratch_q, shift_q} <= {scratch_fix_d, shift_q} << 1;
                    bitcnt_q             <= bitcnt_q + CW'(1);
                    if (bitcnt_q == CW'(BW - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    tens_q   <= scratch_q[7:4];
                    ones_q   <= scratch_q[3:0];
                    update_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign digit_d = (sel_q == SEL_TENS) ? tens_q : ones_q;

    bcd_to_seg7 u_bcd_to_seg7 (
        .digit_i (digit_d),
        .seg_o   (seg_raw_d)
    );

    // Leading-zero handling for the tens position
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        if ((sel_q == SEL_TENS) && (tens_q == 4'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_raw_d;
        end
`else
        seg_d = seg_raw_d;
`endif
    end

    // Refresh counter, digit toggle on wrap, registered segment drive
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refresh_q <= '0;
            sel_q     <= SEL_ONES;
            seg_q     <= SEG_0;
        end else begin
            refresh_q <= refresh_q + REFRESH_W'(1);
            if (&refresh_q) begin
                sel_q <= (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
            end else begin
                sel_q <= sel_q;
            end
            seg_q <= seg_d;
        end
    end

    assign seg_o       = seg_q;
    assign digit_sel_o = sel_q;
    assign bcd_tens_o  = tens_q;
    assign bcd_ones_o  = ones_q;
    assign update_o    = update_q;

endmodule
